fxp_seq_multiplier: RTL and testbench

- Sequential signed fixed-point multiplier, one shift-add iteration per cycle.
- Sits directly upstream of the 16-bit saturating adder in the neuron datapath.
- Produces weight*activation products in the same Q format and width the adder consumes.
- Rounds and saturates so downstream accumulation never sees a wrapped product.

---
 rtl/fxp_seq_multiplier.sv | 117 +++++++++++
 tb/tb_fxp_seq_multiplier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_seq_multiplier.sv
// Sequential signed fixed-point multiplier: sign-magnitude shift-add, one bit per cycle,
// followed by round-half-away-from-zero and saturation to the BIT_WIDTH Q format.
module fxp_seq_multiplier #(
  parameter int BIT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] x,
  input  logic [BIT_WIDTH-1:0] y,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] result,
  output logic                 ovf
);

  localparam int AW    = 2 * BIT_WIDTH;
  localparam int CNT_W = $clog2(BIT_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);
  localparam logic [AW-1:0]    HALF     = AW'(1) << (FRAC_BITS - 1);
  localparam logic [AW-1:0]    POS_LIM  = {{(BIT_WIDTH + 1){1'b0}}, {(BIT_WIDTH - 1){1'b1}}};
  localparam logic [AW-1:0]    NEG_LIM  = POS_LIM + AW'(1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND} state_t;

  state_t               state, next_state;
  logic                 neg;
  logic [AW-1:0]        mcand;
  logic [BIT_WIDTH-1:0] mplier;
  logic [AW-1:0]        acc;
  logic [CNT_W-1:0]     cnt;

  logic [BIT_WIDTH-1:0] abs_x, abs_y;
  logic [AW-1:0]        mag;
  logic [BIT_WIDTH-1:0] mag_lo;
  logic [BIT_WIDTH-1:0] rnd_result;
  logic                 rnd_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == CNT_LAST) next_state = ROUND;
      ROUND:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Magnitudes are unsigned BIT_WIDTH-bit, so the most negative input maps to 2^(BIT_WIDTH-1).
  always_comb begin
    abs_x = x[BIT_WIDTH-1] ? -x : x;
    abs_y = y[BIT_WIDTH-1] ? -y : y;
  end

  always_comb begin
    mag        = (acc + HALF) >> FRAC_BITS;
    mag_lo     = mag[BIT_WIDTH-1:0];
    rnd_result = neg ? -mag_lo : mag_lo;
    rnd_ovf    = 1'b0;
    if (!neg && mag > POS_LIM) begin
      rnd_result = {1'b0, {(BIT_WIDTH - 1){1'b1}}};
      rnd_ovf    = 1'b1;
    end else if (neg && mag > NEG_LIM) begin
      rnd_result = {1'b1, {(BIT_WIDTH - 1){1'b0}}};
      rnd_ovf    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg    <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            neg    <= x[BIT_WIDTH-1] ^ y[BIT_WIDTH-1];
            mcand  <= {{BIT_WIDTH{1'b0}}, abs_x};
            mplier <= abs_y;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mplier <= mplier >> 1;
          mcand  <= mcand << 1;
          cnt    <= cnt + CNT_W'(1);
        end
        ROUND: begin
          result <= rnd_result;
          ovf    <= rnd_ovf;
          done   <= 1'b1;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_seq_multiplier.sv
// Self-checking bench for fxp_seq_multiplier: directed cases, random operands against an
// integer-arithmetic reference, back-to-back issue, ignored starts and mid-operation reset.
module tb_fxp_seq_multiplier;

  localparam int W = 16;
  localparam int F = 8;
  localparam int LAT = W + 1;

  logic         clk, rst, start;
  logic [W-1:0] x, y;
  logic         busy, done, ovf;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  fxp_seq_multiplier #(.BIT_WIDTH(W), .FRAC_BITS(F)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .result(result), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer product, rounded on magnitude, then clamped to the signed range.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic o);
    longint p, m, lim_pos, lim_neg;
    bit n;
    p = longint'($signed(a)) * longint'($signed(b));
    n = (p < 0);
    m = n ? -p : p;
    m = (m + (longint'(1) << (F - 1))) >> F;
    lim_pos = (longint'(1) << (W - 1)) - 1;
    lim_neg = longint'(1) << (W - 1);
    o = 1'b0;
    if (!n && m > lim_pos) begin
      r = W'(lim_pos); o = 1'b1;
    end else if (n && m > lim_neg) begin
      r = W'(-lim_neg); o = 1'b1;
    end else begin
      r = W'(n ? -m : m);
    end
  endfunction

  // Called at a negedge; drives one start pulse and samples each following negedge until done.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic o,
                       output int lat, output int nbusy, output int ndone);
    x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; x = W'($urandom); y = W'($urandom);
    lat = -1; nbusy = 0; ndone = 0; r = '0; o = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++; r = result; o = ovf; lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int nd, nb;
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (result !== '0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got result=%h ovf=%b busy=%b done=%b exp 0000 0 0 0", result, ovf, busy, done);
    end
    rst = 1'b0;
    nd = 0; nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    checks++;
    if (result !== '0 || ovf !== 1'b0 || nd != 0 || nb != 0) begin
      errors++;
      $display("FAIL reset_idle got result=%h ovf=%b dones=%0d busy_cycles=%0d exp 0000 0 0 0", result, ovf, nd, nb);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [9] = '{16'h0180, 16'hFE80, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000};
    logic [W-1:0] tb [9] = '{16'h0200, 16'h0200, 16'h0100, 16'h7FFF, 16'h0200, 16'h0080, 16'h007F, 16'h0080, 16'h8000};
    logic [W-1:0] te [9] = '{16'h0300, 16'hFD00, 16'h8000, 16'h7FFF, 16'h8000, 16'h0001, 16'h0000, 16'hFFFF, 16'h7FFF};
    logic         to [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] r; logic o; int lat, nb, nd;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      do_op(ta[i], tb[i], r, o, lat, nb, nd);
      checks++;
      if (r !== te[i] || o !== to[i]) begin
        errors++;
        $display("FAIL dir_result[%0d] got %h ovf=%b exp %h ovf=%b", i, r, o, te[i], to[i]);
      end
      checks++;
      if (lat != LAT || nb != LAT || nd != 1) begin
        errors++;
        $display("FAIL dir_timing[%0d] got lat=%0d busy=%0d dones=%0d exp %0d %0d 1", i, lat, nb, nd, LAT, LAT);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er; logic o, eo; int lat, nb, nd;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom); b = W'($urandom);
      if (i % 3 == 0) begin
        a = W'($signed(11'($urandom)));
        b = W'($signed(11'($urandom)));
      end
      model(a, b, er, eo);
      @(negedge clk);
      do_op(a, b, r, o, lat, nb, nd);
      checks++;
      if (r !== er || o !== eo || lat != LAT || nd != 1) begin
        errors++;
        $display("FAIL rand[%0d] x=%h y=%h got %h ovf=%b lat=%0d exp %h ovf=%b lat=%0d", i, a, b, r, o, lat, er, eo, LAT);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, r, er; logic o, eo; int lat, nb, nd;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      a = W'($urandom); b = W'($urandom);
      model(a, b, er, eo);
      do_op(a, b, r, o, lat, nb, nd);
      checks++;
      if (r !== er || o !== eo || lat != LAT || nd != 1 || nb != LAT) begin
        errors++;
        $display("FAIL b2b[%0d] got %h ovf=%b lat=%0d dones=%0d busy=%0d exp %h ovf=%b lat=%0d 1 %0d",
                 i, r, o, lat, nd, nb, er, eo, LAT, LAT);
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] a, b, r, er; logic o, eo; int lat, nd;
    a = 16'h0280; b = 16'hFD00;
    model(a, b, er, eo);
    @(negedge clk);
    x = a; y = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; nd = 0; r = '0; o = 1'b0;
    for (int k = 1; k < 45; k++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) begin r = result; o = ovf; lat = k; end
      end
      start = (k == 5 || k == 10 || k == 16);
      x = W'($urandom); y = W'($urandom);
    end
    start = 1'b0;
    checks++;
    if (nd != 1 || lat != LAT || r !== er || o !== eo) begin
      errors++;
      $display("FAIL busy_ignore got dones=%0d lat=%0d result=%h ovf=%b exp 1 %0d %h %b", nd, lat, r, o, LAT, er, eo);
    end
  endtask

  task automatic test_abort();
    logic [W-1:0] r; logic o; int lat, nb, nd;
    @(negedge clk);
    do_op(16'h0180, 16'h0200, r, o, lat, nb, nd);
    checks++;
    if (r !== 16'h0300 || o !== 1'b0) begin
      errors++;
      $display("FAIL abort_pre got %h ovf=%b exp 0300 0", r, o);
    end
    @(negedge clk);
    x = 16'h0300; y = 16'h0100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (result !== '0 || ovf !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_rst got result=%h ovf=%b busy=%b done=%b exp 0000 0 0 0", result, ovf, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    nd = 0; nb = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    checks++;
    if (nd != 0 || nb != 0) begin
      errors++;
      $display("FAIL abort_quiet got dones=%0d busy_cycles=%0d exp 0 0", nd, nb);
    end
    @(negedge clk);
    do_op(16'hFF00, 16'h0280, r, o, lat, nb, nd);
    checks++;
    if (r !== 16'hFD80 || o !== 1'b0 || lat != LAT || nd != 1) begin
      errors++;
      $display("FAIL abort_after got %h ovf=%b lat=%0d exp fd80 0 %0d", r, o, lat, LAT);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; x = '0; y = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
